// File: rtl/vector_sum_reduce.sv
// vector_sum_reduce: accumulates one VECTOR_SIZE-element vector, delivered as
// PE signed lanes per AXI-Stream beat, into a single full-precision signed sum.
// The sum is emitted as a single-beat AXI-Stream result, followed by an ap_done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for ap_start; no input beats are consumed
// ST_ACCUM | consuming BEATS input beats and adding their lanes into acc
// ST_EMIT  | holding the sum on out0 until the downstream accepts it

module vector_sum_reduce #(
    parameter int PE          = 4,
    parameter int VECTOR_SIZE = 256,
    parameter int IN_W        = 16,
    parameter int ACC_W       = IN_W + $clog2(VECTOR_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [PE*IN_W-1:0]    in0_TDATA,
    input  logic                  in0_TVALID,
    output logic                  in0_TREADY,
    output logic [ACC_W-1:0]      out0_TDATA,
    output logic                  out0_TVALID,
    input  logic                  out0_TREADY
);

    localparam int BEATS = VECTOR_SIZE / PE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // A partial final beat would silently drop lanes, so refuse to elaborate.
    if ((VECTOR_SIZE % PE) != 0) begin : g_bad_pe
        $error("vector_sum_reduce: PE must divide VECTOR_SIZE");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               ap_ready_q, ap_ready_d;
    logic               ap_done_q,  ap_done_d;

    logic [IN_W-1:0]    lane;
    logic [ACC_W-1:0]   lane_sum;

    // Sum of the PE lanes of the current beat, each sign-extended to ACC_W.
    always_comb begin
        lane     = '0;
        lane_sum = '0;
        for (int k = 0; k < PE; k++) begin
            lane     = in0_TDATA[k*IN_W +: IN_W];
            lane_sum = lane_sum + {{(ACC_W-IN_W){lane[IN_W-1]}}, lane};
        end
    end

    // Next-state, accumulator, beat counter and handshake pulse logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        ap_ready_d = 1'b0;
        ap_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    ap_ready_d = 1'b1;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // in0_TREADY is high throughout ACCUM, so TVALID alone marks a handshake.
                if (in0_TVALID) begin
                    acc_d      = acc_q + lane_sum;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out0_TREADY) begin
                    ap_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with async clear; a reset mid-run discards the partial sum.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            ap_ready_q <= 1'b0;
            ap_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            ap_ready_q <= ap_ready_d;
            ap_done_q  <= ap_done_d;
        end
    end

    // Stream-side controls decode straight from state; acc only leaves via EMIT
    // (out0_TVALID), so driving TDATA from acc at all times is harmless.
    assign ap_ready    = ap_ready_q;
    assign ap_done     = ap_done_q;
    assign ap_idle     = (state_q == ST_IDLE);
    assign in0_TREADY  = (state_q == ST_ACCUM);
    assign out0_TVALID = (state_q == ST_EMIT);
    assign out0_TDATA  = acc_q;

endmodule

// File: tb/tb_vector_sum_reduce.sv
// Directed bench for vector_sum_reduce (PE=4, VECTOR_SIZE=16, IN_W=16).
// Inputs change and outputs are sampled on the falling edge; expected sums are
// queued when a vector is driven and popped when the result is taken.

module tb_vector_sum_reduce;

    localparam int PE    = 4;
    localparam int VS    = 16;
    localparam int IN_W  = 16;
    localparam int ACC_W = 20;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic [PE*IN_W-1:0] in0_TDATA;
    logic              in0_TVALID;
    logic              in0_TREADY;
    logic [ACC_W-1:0]  out0_TDATA;
    logic              out0_TVALID;
    logic              out0_TREADY;

    int total;
    int bad;
    logic [ACC_W-1:0] exp_q[$];
    logic [PE*IN_W-1:0] vec [4];

    vector_sum_reduce #(
        .PE          (PE),
        .VECTOR_SIZE (VS),
        .IN_W        (IN_W),
        .ACC_W       (ACC_W)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .in0_TDATA   (in0_TDATA),
        .in0_TVALID  (in0_TVALID),
        .in0_TREADY  (in0_TREADY),
        .out0_TDATA  (out0_TDATA),
        .out0_TVALID (out0_TVALID),
        .out0_TREADY (out0_TREADY)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkd(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference sum: signed lanes added in plain integer arithmetic.
    function automatic logic [ACC_W-1:0] model_sum();
        int acc;
        logic [IN_W-1:0] l;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < PE; j++) begin
                l   = vec[k][j*IN_W +: IN_W];
                acc = acc + int'($signed(l));
            end
        end
        return acc[ACC_W-1:0];
    endfunction

    task automatic fill_all(input logic [IN_W-1:0] v);
        for (int k = 0; k < 4; k++) vec[k] = {PE{v}};
    endtask

    task automatic start_run();
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk1("ap_ready_pulse", ap_ready, 1'b1);
        chk1("accum_tready", in0_TREADY, 1'b1);
        chk1("accum_not_idle", ap_idle, 1'b0);
    endtask

    task automatic send_beats(input int nbeats, input bit gaps);
        int g;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                for (int i = 0; i < g; i++) begin
                    in0_TVALID = 1'b0;
                    in0_TDATA  = '0;
                    @(negedge ap_clk);
                    chk1("gap_tready", in0_TREADY, 1'b1);
                    chk1("gap_no_emit", out0_TVALID, 1'b0);
                end
            end
            in0_TDATA  = vec[k];
            in0_TVALID = 1'b1;
            @(negedge ap_clk);
            if (k == 0) chk1("ap_ready_drop", ap_ready, 1'b0);
        end
        in0_TVALID = 1'b0;
        if (nbeats == 4) begin
            exp_q.push_back(model_sum());
            chk1("tvalid_latency", out0_TVALID, 1'b1);
            chk1("emit_tready_low", in0_TREADY, 1'b0);
        end
    endtask

    // Waits for the result, optionally stalls, then takes it; returns on the ap_done cycle.
    task automatic collect(input int stall, input bit poke_start);
        int n;
        logic [ACC_W-1:0] held;
        logic [ACC_W-1:0] expv;
        n = 0;
        while (!out0_TVALID && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        chk1("result_valid", out0_TVALID, 1'b1);
        held = out0_TDATA;
        for (int i = 0; i < stall; i++) begin
            if (poke_start && i == 4) ap_start = 1'b1;
            @(negedge ap_clk);
            if (poke_start && i == 4) begin
                ap_start = 1'b0;
                chk1("start_ignored", ap_ready, 1'b0);
            end
            chkd("emit_stable", out0_TDATA, held);
            chk1("emit_valid_hold", out0_TVALID, 1'b1);
            chk1("emit_no_in_tready", in0_TREADY, 1'b0);
            chk1("no_done_in_stall", ap_done, 1'b0);
        end
        out0_TREADY = 1'b1;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=%0d", exp_q.size(), 1);
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chkd("result", out0_TDATA, expv);
        @(negedge ap_clk);
        chk1("ap_done_pulse", ap_done, 1'b1);
        chk1("done_idle", ap_idle, 1'b1);
        chk1("done_tvalid_low", out0_TVALID, 1'b0);
    endtask

    task automatic done_drop();
        @(negedge ap_clk);
        chk1("ap_done_drop", ap_done, 1'b0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        in0_TDATA   = '0;
        in0_TVALID  = 1'b0;
        out0_TREADY = 1'b0;

        // Reset state
        repeat (2) @(negedge ap_clk);
        chk1("rst_idle", ap_idle, 1'b1);
        chk1("rst_ready", ap_ready, 1'b0);
        chk1("rst_done", ap_done, 1'b0);
        chk1("rst_in_tready", in0_TREADY, 1'b0);
        chk1("rst_out_tvalid", out0_TVALID, 1'b0);
        chkd("rst_out_tdata", out0_TDATA, '0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk1("idle_no_tready", in0_TREADY, 1'b0);

        // All lanes = 1, downstream always ready
        out0_TREADY = 1'b1;
        fill_all(16'd1);
        start_run();
        send_beats(4, 1'b0);
        collect(0, 1'b0);
        done_drop();

        // Most negative and most positive lanes: no wrap in ACC_W
        fill_all(16'h8000);
        start_run();
        send_beats(4, 1'b0);
        chkd("min_const", out0_TDATA, 20'h80000);
        collect(0, 1'b0);
        done_drop();
        fill_all(16'h7FFF);
        start_run();
        send_beats(4, 1'b0);
        chkd("max_const", out0_TDATA, 20'h7FFF0);
        collect(0, 1'b0);
        done_drop();

        // Lanes {k,-k,2k,0} with random TVALID gaps; extra valid data must not be taken
        for (int k = 0; k < 4; k++)
            vec[k] = {16'h0, 16'(2*k), 16'(-k), 16'(k)};
        out0_TREADY = 1'b0;
        start_run();
        send_beats(4, 1'b1);
        chkd("mixed_const", out0_TDATA, 20'd12);
        in0_TVALID = 1'b1;
        in0_TDATA  = {PE{16'h1234}};
        collect(3, 1'b0);
        chk1("idle_no_extra_beat", in0_TREADY, 1'b0);
        in0_TVALID = 1'b0;
        done_drop();

        // Backpressure for 10 cycles, stray ap_start mid-run
        fill_all(16'd2);
        out0_TREADY = 1'b0;
        start_run();
        send_beats(4, 1'b0);
        collect(10, 1'b1);
        done_drop();

        // Reset after 2 beats, then a clean run of lanes=3
        fill_all(16'd5);
        start_run();
        send_beats(2, 1'b0);
        in0_TVALID = 1'b1;
        in0_TDATA  = vec[2];
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk1("midrst_in_tready", in0_TREADY, 1'b0);
        chk1("midrst_idle", ap_idle, 1'b1);
        chkd("midrst_tdata", out0_TDATA, '0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            chk1("post_rst_no_consume", in0_TREADY, 1'b0);
        end
        out0_TREADY = 1'b1;
        fill_all(16'd3);
        start_run();
        send_beats(4, 1'b0);
        chkd("after_abort_const", out0_TDATA, 20'd48);
        collect(0, 1'b0);
        done_drop();

        // Back-to-back: start asserted in the ap_done cycle
        fill_all(16'd1);
        start_run();
        send_beats(4, 1'b0);
        collect(0, 1'b0);
        fill_all(16'd3);
        start_run();
        send_beats(4, 1'b0);
        collect(0, 1'b0);
        done_drop();
        chk1("queue_drained", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
